core_top: RTL and testbench
===========================

// Module: core_top
// PURPOSE
//  Top level of the single-cycle RV32I processor; the whole CPU with no external bus.
//  Holds the PC, decoder, ALU, branch unit, register file and a unified instruction/data RAM.
//  The RAM is preloaded by the bench through $readmemh.
//  Test programs signal completion through x26 (done) and x27 (pass).
//  x3 (gp) holds the current test number.
// PARAMETERS
//  MEM_AW     12            word-address width of unified RAM (4096 x 32-bit words = 16 KiB)
//  RESET_PC   32'h0000_0000 PC value loaded on reset
// PORTS
//  clk   input  1  single clock; all state updates on rising edge
//  rst   input  1  synchronous, active-high reset
//  (no other ports)
// BEHAVIOUR
//  Hierarchy contract (the bench accesses these paths directly):
//  - Register file: instance u_Registers, array regfile[0:31] of 32 bits.
//  - RAM: instance u_InstCatch containing u_ramGen, array ram[0:2**MEM_AW-1] of 32 bits.
//  - ram is word-addressed, little-endian; hex word N is byte address 4N.
//  Reset:
//  - While rst=1 at a posedge: PC<=RESET_PC; regfile[0..31]<=0.
//  - RAM is never cleared by reset, so preloaded contents survive.
//  Execution:
//  - One instruction retires per clock after rst deasserts. There is no pipeline, stall or hazard logic.
//  - Fetch: inst = ram[PC[MEM_AW+1:2]], combinational (asynchronous) read.
//  - Decode/execute is combinational. At posedge: rd written, PC updated, store committed.
//  - Supported ISA is full RV32I user integer set:
//    LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
//    LB/LH/LW/LBU/LHU, SB/SH/SW.
//    ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
//    ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
//  - Next PC: PC+4 by default; PC+immB if branch taken; PC+immJ for JAL.
//  - JALR target is (rs1+immI)&~1. rd gets PC+4 for JAL/JALR.
//  - Shifts use the low 5 bits of shamt/rs2. SRA/SRAI are arithmetic.
//  - SLT is signed; SLTU and SLTIU are unsigned compare after sign-extending the immediate.
//  - x0 reads 0 always; writes to x0 are discarded.
//  - Reads of rs1/rs2 see the pre-edge value. No internal forwarding is needed (single cycle).
//  Memory (data side on same RAM array, second port):
//  - Load data is combinational from ram[addr[MEM_AW+1:2]].
//  - Byte lane selected by addr[1:0]; halfword lane selected by addr[1].
//  - LB/LH sign-extend; LBU/LHU zero-extend.
//  - Stores write at posedge with byte enables: SB one lane, SH lanes by addr[1], SW all four.
//  - Misaligned accesses are truncated to natural alignment (no trap).
//  - Address bits above MEM_AW+1 are ignored, so addresses wrap modulo RAM size.
//  - A store may overwrite an instruction. The new word is fetched the next time that PC is reached.
//  Other encodings:
//  - FENCE, ECALL, EBREAK, CSR ops and unknown opcodes execute as NOP (PC+4, no writes).
//  - There are no traps or interrupts.
//  - rst asserted mid-program returns PC to RESET_PC and zeroes registers at the next edge. RAM is kept.
// TESTING
//  - Reset: hold rst 4 cycles -> PC=0, all regfile=0; first fetch at 0 on the first edge after release.
//  - ALU: addi x1,x0,-1; srli x2,x1,4; srai x3,x1,4; sltu x4,x0,x1
//    -> x2=0x0FFF_FFFF, x3=0xFFFF_FFFF, x4=1.
//  - Memory: sw 0x8081_8283 at 0x400; lb/lbu/lh/lhu from 0x400
//    -> 0xFFFF_FF83, 0x83, 0xFFFF_8283, 0x8283; sb 0x55 at 0x401 -> lw=0x8081_5583.
//  - Control: bne taken skips an addi; jal x1,+8 at 0x20 gives x1=0x24 and PC=0x28;
//    jalr x0,3(x5) with x5=0x40 gives PC=0x42.
//  - x0: addi x0,x0,5 then add x6,x0,x0 -> x6=0.
//  - Self-check program: full RV32I suite ending with x26=1 and x27=1.
//    -> done within 50,000 cycles; a deliberate failure leaves x27=0 and x3=failing test number.

Source files
------------

// File: rtl/core_top.sv
// Single-cycle RV32I CPU with a unified instruction/data RAM.
// Fetch, decode, execute and memory access all complete in one clock.

module core_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] ia_i,
    output logic [31:0]   id_o,
    input  logic [AW-1:0] da_i,
    output logic [31:0]   dd_o,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wd_i
);
    logic [31:0] ram [0:2**AW-1];

    assign id_o = ram[ia_i];
    assign dd_o = ram[da_i];

    // Byte-lane store; plain process because the array is also backdoor-loaded
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) ram[da_i][8*b +: 8] <= wd_i[8*b +: 8];
        end
    end
endmodule

module core_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] ia_i,
    output logic [31:0]   id_o,
    input  logic [AW-1:0] da_i,
    output logic [31:0]   dd_o,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wd_i
);
    core_ram #(.AW(AW)) u_ramGen (
        .clk  (clk),
        .ia_i (ia_i),
        .id_o (id_o),
        .da_i (da_i),
        .dd_o (dd_o),
        .be_i (be_i),
        .wd_i (wd_i)
    );
endmodule

module core_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] regfile [0:31];

    assign rd1_o = regfile[ra1_i];
    assign rd2_o = regfile[ra2_i];

    // Register write; x0 never written so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            regfile[wa_i] <= wd_i;
        end
    end
endmodule

module core_top #(
    parameter int          MEM_AW   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst, rs1_v, rs2_v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y, sra_y, ls_addr;
    logic [31:0] ld_word, ld_sh, ld_val, st_wd;
    logic [15:0] ld_h;
    logic [3:0]  st_be, mem_be;
    logic [4:0]  shamt;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        taken, rf_we;
    logic [31:0] rf_wd;
    logic        is_lui, is_aui, is_jal, is_jlr;
    logic        is_br, is_ld, is_st, is_imm, is_reg;
    logic        unused;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];

    assign is_lui = (opc == OP_LUI);
    assign is_aui = (opc == OP_AUI);
    assign is_jal = (opc == OP_JAL);
    assign is_jlr = (opc == OP_JLR);
    assign is_br  = (opc == OP_BR);
    assign is_ld  = (opc == OP_LD);
    assign is_st  = (opc == OP_ST);
    assign is_imm = (opc == OP_IMM);
    assign is_reg = (opc == OP_REG);

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    assign ls_addr = rs1_v + (is_st ? imm_s : imm_i);
    assign sra_y   = $unsigned($signed(rs1_v) >>> shamt);
    assign ld_sh   = ld_word >> {ls_addr[1:0], 3'b000};
    assign ld_h    = ls_addr[1] ? ld_word[31:16] : ld_word[15:0];
    assign unused  = ^{ls_addr[31:MEM_AW+2], ld_sh[31:8]};

    core_mem #(.AW(MEM_AW)) u_InstCatch (
        .clk  (clk),
        .ia_i (pc_q[MEM_AW+1:2]),
        .id_o (inst),
        .da_i (ls_addr[MEM_AW+1:2]),
        .dd_o (ld_word),
        .be_i (rst ? 4'b0000 : mem_be),
        .wd_i (st_wd)
    );

    core_regs u_Registers (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (inst[19:15]),
        .ra2_i (inst[24:20]),
        .we_i  (rf_we),
        .wa_i  (inst[11:7]),
        .wd_i  (rf_wd),
        .rd1_o (rs1_v),
        .rd2_o (rs2_v)
    );

    // ALU for register and immediate arithmetic
    always_comb begin
        alu_b = is_reg ? rs2_v : imm_i;
        shamt = alu_b[4:0];
        alu_y = '0;
        unique case (f3)
            3'b000: alu_y = (is_reg && inst[30]) ? rs1_v - alu_b
                                                 : rs1_v + alu_b;
            3'b001: alu_y = rs1_v << shamt;
            3'b010: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'b011: alu_y = {31'b0, rs1_v < alu_b};
            3'b100: alu_y = rs1_v ^ alu_b;
            3'b101: alu_y = inst[30] ? sra_y : rs1_v >> shamt;
            3'b110: alu_y = rs1_v | alu_b;
            3'b111: alu_y = rs1_v & alu_b;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        taken = 1'b0;
        unique case (f3)
            3'b000:  taken = (rs1_v == rs2_v);
            3'b001:  taken = (rs1_v != rs2_v);
            3'b100:  taken = ($signed(rs1_v) < $signed(rs2_v));
            3'b101:  taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110:  taken = (rs1_v < rs2_v);
            3'b111:  taken = (rs1_v >= rs2_v);
            default: taken = 1'b0;
        endcase
    end

    // Load lane extraction and store lane replication
    always_comb begin
        ld_val = ld_word;
        st_wd  = rs2_v;
        st_be  = 4'b0000;
        unique case (f3)
            3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_val = {24'b0, ld_sh[7:0]};
            3'b101:  ld_val = {16'b0, ld_h};
            default: ld_val = ld_word;
        endcase
        unique case (f3)
            3'b000: begin
                st_wd = {4{rs2_v[7:0]}};
                st_be = 4'b0001 << ls_addr[1:0];
            end
            3'b001: begin
                st_wd = {2{rs2_v[15:0]}};
                st_be = ls_addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010:  st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    // Next PC, register writeback and store enable
    always_comb begin
        pc_d   = pc_q + 32'd4;
        rf_we  = 1'b0;
        rf_wd  = '0;
        mem_be = 4'b0000;
        unique case (1'b1)
            is_lui: begin
                rf_we = 1'b1;
                rf_wd = imm_u;
            end
            is_aui: begin
                rf_we = 1'b1;
                rf_wd = pc_q + imm_u;
            end
            is_jal: begin
                rf_we = 1'b1;
                rf_wd = pc_q + 32'd4;
                pc_d  = pc_q + imm_j;
            end
            is_jlr: begin
                rf_we = 1'b1;
                rf_wd = pc_q + 32'd4;
                pc_d  = (rs1_v + imm_i) & ~32'd1;
            end
            is_br: begin
                if (taken) pc_d = pc_q + imm_b;
            end
            is_ld: begin
                rf_we = 1'b1;
                rf_wd = ld_val;
            end
            is_st:  mem_be = st_be;
            is_imm, is_reg: begin
                rf_we = 1'b1;
                rf_wd = alu_y;
            end
            default: ;
        endcase
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end
endmodule

// File: tb/tb_core_top.sv
// Directed bench for core_top: small programs are backdoor-loaded
// into RAM, run for a known cycle count, then registers are compared.

module tb_core_top;
    localparam logic [6:0] LUI = 7'h37, JAL = 7'h6f, JALR = 7'h67;
    localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23;
    localparam logic [6:0] OPI = 7'h13, OP = 7'h33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] prog [$];

    core_top #(.MEM_AW(12), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.u_Registers.regfile[i];
    endfunction

    function automatic logic [31:0] ei(input logic [31:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] er(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] es(input logic [31:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
    endfunction

    function automatic logic [31:0] eb(input logic [31:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
    endfunction

    function automatic logic [31:0] eu(input logic [19:0] imm,
        input logic [4:0] rd);
        return {imm, rd, LUI};
    endfunction

    function automatic logic [31:0] ej(input logic [31:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    task automatic emit(input logic [31:0] w);
        prog.push_back(w);
    endtask

    // Called at a negedge with rst already high
    task automatic load();
        for (int i = 0; i < 64; i++) dut.u_InstCatch.u_ramGen.ram[i] = '0;
        foreach (prog[i]) dut.u_InstCatch.u_ramGen.ram[i] = prog[i];
        prog.delete();
    endtask

    task automatic start();
        @(negedge clk);
        rst = 1'b1;
        load();
        repeat (4) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic selfcheck_prog(input logic [31:0] t2_exp);
        emit(ei(1, 0, 0, 3, OPI));
        emit(ei(5, 0, 0, 1, OPI));
        emit(ei(-3, 0, 0, 2, OPI));
        emit(er(0, 2, 1, 0, 4));
        emit(ei(2, 0, 0, 5, OPI));
        emit(eb(32'h3C, 5, 4, 1));
        emit(ei(2, 0, 0, 3, OPI));
        emit(er(0, 1, 2, 2, 4));
        emit(ei(t2_exp, 0, 0, 5, OPI));
        emit(eb(32'h2C, 5, 4, 1));
        emit(ei(3, 0, 0, 3, OPI));
        emit(er(0, 1, 2, 3, 4));
        emit(eb(32'h20, 0, 4, 1));
        emit(ei(4, 0, 0, 3, OPI));
        emit(er(7'h20, 2, 1, 0, 4));
        emit(ei(8, 0, 0, 5, OPI));
        emit(eb(32'h10, 5, 4, 1));
        emit(ei(1, 0, 0, 27, OPI));
        emit(ei(1, 0, 0, 26, OPI));
        emit(ej(0, 0));
        emit(ei(1, 0, 0, 26, OPI));
        emit(ej(0, 0));
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (rf(26) != 32'd1 && cyc < 50000) begin
            @(negedge clk);
            cyc++;
        end
        check("done", rf(26), 32'd1);
    endtask

    initial begin
        logic [31:0] acc;
        logic [31:0] w0;
        for (int i = 0; i < 4096; i++) dut.u_InstCatch.u_ramGen.ram[i] = '0;

        // ALU
        emit(ei(-1, 0, 0, 1, OPI));
        emit(ei(4, 1, 5, 2, OPI));
        emit(ei(32'h404, 1, 5, 3, OPI));
        emit(er(0, 1, 0, 3, 4));
        emit(eu(20'h80000, 7));
        emit(ei(36, 0, 0, 5, OPI));
        emit(er(7'h20, 5, 7, 5, 8));
        emit(er(0, 5, 7, 5, 9));
        emit(ei(0, 1, 2, 10, OPI));
        emit(ei(-1, 0, 3, 11, OPI));
        w0 = ei(-1, 0, 0, 1, OPI);
        start();
        check("rst_pc", dut.pc_q, 32'h0);
        run(10);
        check("srli", rf(2), 32'h0FFF_FFFF);
        check("srai", rf(3), 32'hFFFF_FFFF);
        check("sltu", rf(4), 32'd1);
        check("sra_r", rf(8), 32'hF800_0000);
        check("srl_r", rf(9), 32'h0800_0000);
        check("slti", rf(10), 32'd1);
        check("sltiu", rf(11), 32'd1);

        // Mid-program reset keeps RAM, clears PC and registers
        rst = 1'b1;
        run(4);
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc | rf(i);
        check("rst_pc2", dut.pc_q, 32'h0);
        check("rst_rf", acc, 32'h0);
        check("rst_ram", dut.u_InstCatch.u_ramGen.ram[0], w0);
        rst = 1'b0;

        // Memory
        emit(eu(20'h80818, 1));
        emit(ei(32'h283, 1, 0, 1, OPI));
        emit(ei(32'h400, 0, 0, 2, OPI));
        emit(es(0, 1, 2, 2));
        emit(ei(0, 2, 0, 3, LD));
        emit(ei(0, 2, 4, 4, LD));
        emit(ei(0, 2, 1, 5, LD));
        emit(ei(0, 2, 5, 6, LD));
        emit(ei(2, 2, 1, 9, LD));
        emit(ei(32'h55, 0, 0, 7, OPI));
        emit(es(1, 7, 2, 0));
        emit(ei(0, 2, 2, 8, LD));
        emit(eu(20'h00004, 11));
        emit(er(0, 2, 11, 0, 11));
        emit(ei(0, 11, 2, 10, LD));
        emit(es(2, 7, 2, 1));
        emit(ei(0, 2, 2, 12, LD));
        start();
        run(17);
        check("lb", rf(3), 32'hFFFF_FF83);
        check("lbu", rf(4), 32'h0000_0083);
        check("lh", rf(5), 32'hFFFF_8283);
        check("lhu", rf(6), 32'h0000_8283);
        check("lh_hi", rf(9), 32'hFFFF_8081);
        check("sb_lw", rf(8), 32'h8081_5583);
        check("wrap", rf(10), 32'h8081_5583);
        check("sh_lw", rf(12), 32'h0055_5583);
        check("ram400", dut.u_InstCatch.u_ramGen.ram[256], 32'h0055_5583);

        // Control
        emit(ei(32'h40, 0, 0, 5, OPI));
        emit(ei(1, 0, 0, 7, OPI));
        emit(eb(8, 0, 7, 1));
        emit(ei(1, 0, 0, 8, OPI));
        emit(ei(2, 0, 0, 9, OPI));
        emit(ej(12, 0));
        emit(32'h0);
        emit(32'h0);
        emit(ej(8, 1));
        emit(ei(1, 0, 0, 10, OPI));
        emit(ei(3, 5, 0, 0, JALR));
        start();
        run(6);
        check("jal_pc", dut.pc_q, 32'h28);
        check("jal_ra", rf(1), 32'h24);
        run(1);
        check("jalr_pc", dut.pc_q, 32'h42);
        check("bne_skip", rf(8), 32'h0);
        check("bne_tgt", rf(9), 32'd2);
        check("jal_skip", rf(10), 32'h0);

        // x0 hardwired
        emit(ei(7, 0, 0, 6, OPI));
        emit(ei(5, 0, 0, 0, OPI));
        emit(er(0, 0, 0, 0, 6));
        start();
        run(1);
        check("x6_pre", rf(6), 32'd7);
        run(2);
        check("x0", rf(0), 32'h0);
        check("x6_zero", rf(6), 32'h0);

        // Store over an instruction ahead of the PC
        emit(eu(20'h00700, 1));
        emit(ei(32'h113, 1, 0, 1, OPI));
        emit(es(16, 1, 0, 2));
        emit(ei(0, 0, 0, 0, OPI));
        emit(ei(1, 0, 0, 2, OPI));
        start();
        run(5);
        check("selfmod", rf(2), 32'd7);

        // Self-check program, passing variant
        selfcheck_prog(32'd1);
        start();
        wait_done();
        check("pass", rf(27), 32'd1);
        check("pass_tn", rf(3), 32'd4);

        // Self-check program with test 2 sabotaged
        selfcheck_prog(32'd0);
        start();
        wait_done();
        check("fail_flag", rf(27), 32'd0);
        check("fail_tn", rf(3), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
